// File: rtl/eth_lane_mux_pkg.sv
// Shared types and constants for the multi-lane Ethernet AXI-Stream mux.
package eth_lane_mux_pkg;

    typedef enum logic {
        RxIdle,
        RxPkt
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxFwd,
        TxDrop
    } tx_state_e;

    localparam int unsigned LINK_UP_BIT = 0;
    localparam int unsigned CNT_W       = 32;
    // tx_lane_sel / stat_lane width and the number of lanes it can address
    localparam int unsigned SEL_W       = 3;
    localparam int unsigned MAX_LANES   = 8;

    // Width of a lane index; at least one bit even for two lanes.
    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        if (lanes <= 2) begin
            return 1;
        end
        return $unsigned($clog2(lanes));
    endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting lane after ptr_i, wrapping.
module eth_rr_arbiter
    import eth_lane_mux_pkg::*;
#(
    parameter int unsigned Lanes = 4,
    localparam int unsigned IdxW = lane_idx_w(Lanes)
) (
    input  logic [Lanes-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [Lanes-1:0] gnt_o,
    output logic [IdxW-1:0]  gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [IdxW-1:0] cand;

    // Scan lanes ptr+1 .. ptr+Lanes (mod Lanes); the last candidate is ptr itself.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = '0;
        for (int unsigned off = 1; off <= Lanes; off++) begin
            cand = IdxW'((32'(ptr_i) + off) % Lanes);
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_axis_lane_mux.sv
// SoC Ethernet AXI-Stream port to LANES MAC lanes: packet-atomic round-robin RX
// merge, software-steered TX with drop on link-down or invalid lane.
// Optional per-lane packet/drop counters: define ETH_LANE_MUX_STATS_EN.
module eth_axis_lane_mux
    import eth_lane_mux_pkg::*;
#(
    parameter int unsigned LANES    = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned STATUS_W = 16,
    localparam int unsigned KEEP_W  = DATA_W / 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          tx_lane_sel,
    input  logic [DATA_W-1:0]         s_tx_tdata,
    input  logic [KEEP_W-1:0]         s_tx_tkeep,
    input  logic                      s_tx_tuser,
    input  logic                      s_tx_tlast,
    input  logic                      s_tx_tvalid,
    output logic                      s_tx_tready,
    output logic [LANES*DATA_W-1:0]   m_tx_tdata,
    output logic [LANES*KEEP_W-1:0]   m_tx_tkeep,
    output logic [LANES-1:0]          m_tx_tuser,
    output logic [LANES-1:0]          m_tx_tlast,
    output logic [LANES-1:0]          m_tx_tvalid,
    input  logic [LANES-1:0]          m_tx_tready,
    input  logic [LANES*DATA_W-1:0]   s_rx_tdata,
    input  logic [LANES*KEEP_W-1:0]   s_rx_tkeep,
    input  logic [LANES-1:0]          s_rx_tuser,
    input  logic [LANES-1:0]          s_rx_tlast,
    input  logic [LANES-1:0]          s_rx_tvalid,
    output logic [LANES-1:0]          s_rx_tready,
    output logic [DATA_W-1:0]         m_rx_tdata,
    output logic [KEEP_W-1:0]         m_rx_tkeep,
    output logic                      m_rx_tuser,
    output logic                      m_rx_tlast,
    output logic                      m_rx_tvalid,
    input  logic                      m_rx_tready,
    input  logic [LANES*STATUS_W-1:0] lane_status,
    output logic [STATUS_W-1:0]       eth_status,
    input  logic [SEL_W-1:0]          stat_lane,
    output logic [CNT_W-1:0]          stat_rx_pkts,
    output logic [CNT_W-1:0]          stat_tx_drops
);

    localparam int unsigned IdxW = lane_idx_w(LANES);

    logic [DATA_W-1:0]   rx_data [LANES];
    logic [KEEP_W-1:0]   rx_keep [LANES];

    // Lane views padded to the full select range; missing lanes read as link-down / zero.
    logic [MAX_LANES-1:0] link_up_pad;
    logic [MAX_LANES-1:0] tx_ready_pad;
    logic [STATUS_W-1:0]  status_pad [MAX_LANES];

    rx_state_e       rx_state_q, rx_state_d;
    logic [IdxW-1:0] rx_gnt_q, rx_gnt_d;
    logic [LANES-1:0] rx_gnt_oh_q, rx_gnt_oh_d;
    logic [IdxW-1:0] rx_ptr_q, rx_ptr_d;
    logic [LANES-1:0] arb_gnt_oh;
    logic [IdxW-1:0] arb_gnt_idx;
    logic            arb_gnt_valid;
    logic            rx_active;
    logic            rx_last_fire;

    tx_state_e        tx_state_q, tx_state_d;
    logic [SEL_W-1:0] tx_lane_q, tx_lane_d;
    logic             tx_fwd;
    logic             tx_drop;
    logic             tx_last_fire;

    logic [STATUS_W-1:0] eth_status_q;

    for (genvar g = 0; g < LANES; g++) begin : gen_lane_io
        assign rx_data[g] = s_rx_tdata[g*DATA_W +: DATA_W];
        assign rx_keep[g] = s_rx_tkeep[g*KEEP_W +: KEEP_W];
        // TX payload is broadcast; only the steered lane sees tvalid.
        assign m_tx_tdata[g*DATA_W +: DATA_W] = s_tx_tdata;
        assign m_tx_tkeep[g*KEEP_W +: KEEP_W] = s_tx_tkeep;
        assign m_tx_tuser[g]  = s_tx_tuser;
        assign m_tx_tlast[g]  = s_tx_tlast;
        assign m_tx_tvalid[g] = tx_fwd & s_tx_tvalid & (tx_lane_q == SEL_W'(g));
    end

    // Build padded per-lane status/ready views.
    always_comb begin
        link_up_pad  = '0;
        tx_ready_pad = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            status_pad[i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            status_pad[i]   = lane_status[i*STATUS_W +: STATUS_W];
            link_up_pad[i]  = status_pad[i][LINK_UP_BIT];
            tx_ready_pad[i] = m_tx_tready[i];
        end
    end

    eth_rr_arbiter #(
        .Lanes(LANES)
    ) u_rx_arb (
        .req_i      (s_rx_tvalid),
        .ptr_i      (rx_ptr_q),
        .gnt_o      (arb_gnt_oh),
        .gnt_idx_o  (arb_gnt_idx),
        .gnt_valid_o(arb_gnt_valid)
    );

    // RX datapath: granted lane routed straight through while a packet is open.
    assign rx_active    = (rx_state_q == RxPkt);
    assign m_rx_tvalid  = rx_active & s_rx_tvalid[rx_gnt_q];
    assign m_rx_tdata   = rx_active ? rx_data[rx_gnt_q] : '0;
    assign m_rx_tkeep   = rx_active ? rx_keep[rx_gnt_q] : '0;
    assign m_rx_tuser   = rx_active & s_rx_tuser[rx_gnt_q];
    assign m_rx_tlast   = rx_active & s_rx_tlast[rx_gnt_q];
    assign s_rx_tready  = rx_active ? (rx_gnt_oh_q & {LANES{m_rx_tready}}) : '0;
    assign rx_last_fire = m_rx_tvalid & m_rx_tready & m_rx_tlast;

    // RX next state: grant is registered in idle and held until the packet's tlast.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_gnt_d    = rx_gnt_q;
        rx_gnt_oh_d = rx_gnt_oh_q;
        rx_ptr_d    = rx_ptr_q;
        case (rx_state_q)
            RxIdle: begin
                if (arb_gnt_valid) begin
                    rx_gnt_d    = arb_gnt_idx;
                    rx_gnt_oh_d = arb_gnt_oh;
                    rx_state_d  = RxPkt;
                end
            end
            RxPkt: begin
                if (rx_last_fire) begin
                    rx_ptr_d   = rx_gnt_q;
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX state register; pointer resets to the last lane so lane 0 wins first.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q  <= RxIdle;
            rx_gnt_q    <= '0;
            rx_gnt_oh_q <= '0;
            rx_ptr_q    <= IdxW'(LANES - 1);
        end else begin
            rx_state_q  <= rx_state_d;
            rx_gnt_q    <= rx_gnt_d;
            rx_gnt_oh_q <= rx_gnt_oh_d;
            rx_ptr_q    <= rx_ptr_d;
        end
    end

    // TX handshake: idle is a decision cycle, drop sinks everything.
    assign tx_fwd       = (tx_state_q == TxFwd);
    assign tx_drop      = (tx_state_q == TxDrop);
    assign s_tx_tready  = tx_fwd ? tx_ready_pad[tx_lane_q] : tx_drop;
    assign tx_last_fire = s_tx_tvalid & s_tx_tready & s_tx_tlast;

    // TX next state: lane and link state are latched once, at packet start.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_lane_d  = tx_lane_q;
        case (tx_state_q)
            TxIdle: begin
                if (s_tx_tvalid) begin
                    tx_lane_d  = tx_lane_sel;
                    tx_state_d = link_up_pad[tx_lane_sel] ? TxFwd : TxDrop;
                end
            end
            TxFwd, TxDrop: begin
                if (tx_last_fire) begin
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // TX state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_lane_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_lane_q  <= tx_lane_d;
        end
    end

    // Status of the currently selected TX lane, one cycle behind the select.
    always_ff @(posedge clock) begin
        if (reset) begin
            eth_status_q <= '0;
        end else begin
            eth_status_q <= status_pad[tx_lane_sel];
        end
    end

    assign eth_status = eth_status_q;

`ifdef ETH_LANE_MUX_STATS_EN
    logic [CNT_W-1:0] rx_pkts_arr  [LANES];
    logic [CNT_W-1:0] tx_drops_arr [LANES];

    for (genvar g = 0; g < LANES; g++) begin : gen_stats
        logic [CNT_W-1:0] rx_pkts_q;
        logic [CNT_W-1:0] tx_drops_q;

        // Saturating per-lane packet and drop counters.
        always_ff @(posedge clock) begin
            if (reset) begin
                rx_pkts_q  <= '0;
                tx_drops_q <= '0;
            end else begin
                if (rx_last_fire && (rx_gnt_q == IdxW'(g)) && (rx_pkts_q != '1)) begin
                    rx_pkts_q <= rx_pkts_q + 1'b1;
                end
                if (tx_drop && tx_last_fire && (tx_lane_q == SEL_W'(g)) &&
                    (tx_drops_q != '1)) begin
                    tx_drops_q <= tx_drops_q + 1'b1;
                end
            end
        end

        assign rx_pkts_arr[g]  = rx_pkts_q;
        assign tx_drops_arr[g] = tx_drops_q;
    end

    // Counter readout; selects beyond the lane count read zero.
    always_comb begin
        stat_rx_pkts  = '0;
        stat_tx_drops = '0;
        for (int i = 0; i < LANES; i++) begin
            if (stat_lane == SEL_W'(i)) begin
                stat_rx_pkts  = rx_pkts_arr[i];
                stat_tx_drops = tx_drops_arr[i];
            end
        end
    end
`else
    logic unused_stat_lane;

    assign unused_stat_lane = ^stat_lane;
    assign stat_rx_pkts     = '0;
    assign stat_tx_drops    = '0;
`endif

endmodule

// File: tb/tb_eth_axis_lane_mux.sv
// Scoreboard bench for eth_axis_lane_mux (4 lanes, 64-bit data).
module tb_eth_axis_lane_mux;

    localparam int LANES = 4;
    localparam int DW    = 64;
    localparam int KW    = 8;
    localparam int SW    = 16;
`ifdef ETH_LANE_MUX_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]    lane;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          user;
        logic          last;
    } beat_t;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [2:0]           tx_lane_sel;
    logic [DW-1:0]        s_tx_tdata;
    logic [KW-1:0]        s_tx_tkeep;
    logic                 s_tx_tuser, s_tx_tlast, s_tx_tvalid, s_tx_tready;
    logic [LANES*DW-1:0]  m_tx_tdata;
    logic [LANES*KW-1:0]  m_tx_tkeep;
    logic [LANES-1:0]     m_tx_tuser, m_tx_tlast, m_tx_tvalid, m_tx_tready;
    logic [LANES*DW-1:0]  s_rx_tdata;
    logic [LANES*KW-1:0]  s_rx_tkeep;
    logic [LANES-1:0]     s_rx_tuser, s_rx_tlast, s_rx_tvalid, s_rx_tready;
    logic [DW-1:0]        m_rx_tdata;
    logic [KW-1:0]        m_rx_tkeep;
    logic                 m_rx_tuser, m_rx_tlast, m_rx_tvalid, m_rx_tready;
    logic [LANES*SW-1:0]  lane_status;
    logic [SW-1:0]        eth_status;
    logic [2:0]           stat_lane;
    logic [31:0]          stat_rx_pkts, stat_tx_drops;

    beat_t rx_src_q [LANES][$];
    beat_t rx_exp [$];
    beat_t tx_src_q [$];
    beat_t tx_exp [$];

    int n_total = 0;
    int n_bad   = 0;
    int rx_seen = 0;
    int tx_seen = 0;
    int tx_stalls = 0;
    bit tx_rand_rdy = 1'b0;

    always #5 clock = ~clock;

    eth_axis_lane_mux #(
        .LANES(LANES),
        .DATA_W(DW),
        .STATUS_W(SW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tx_lane_sel  (tx_lane_sel),
        .s_tx_tdata   (s_tx_tdata),
        .s_tx_tkeep   (s_tx_tkeep),
        .s_tx_tuser   (s_tx_tuser),
        .s_tx_tlast   (s_tx_tlast),
        .s_tx_tvalid  (s_tx_tvalid),
        .s_tx_tready  (s_tx_tready),
        .m_tx_tdata   (m_tx_tdata),
        .m_tx_tkeep   (m_tx_tkeep),
        .m_tx_tuser   (m_tx_tuser),
        .m_tx_tlast   (m_tx_tlast),
        .m_tx_tvalid  (m_tx_tvalid),
        .m_tx_tready  (m_tx_tready),
        .s_rx_tdata   (s_rx_tdata),
        .s_rx_tkeep   (s_rx_tkeep),
        .s_rx_tuser   (s_rx_tuser),
        .s_rx_tlast   (s_rx_tlast),
        .s_rx_tvalid  (s_rx_tvalid),
        .s_rx_tready  (s_rx_tready),
        .m_rx_tdata   (m_rx_tdata),
        .m_rx_tkeep   (m_rx_tkeep),
        .m_rx_tuser   (m_rx_tuser),
        .m_rx_tlast   (m_rx_tlast),
        .m_rx_tvalid  (m_rx_tvalid),
        .m_rx_tready  (m_rx_tready),
        .lane_status  (lane_status),
        .eth_status   (eth_status),
        .stat_lane    (stat_lane),
        .stat_rx_pkts (stat_rx_pkts),
        .stat_tx_drops(stat_tx_drops)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t mk_beat(input int lane, input int pkt, input int idx, input int nb);
        beat_t b;
        b.lane = 3'(lane);
        b.data = {8'(lane), 8'(pkt), 8'(idx), 8'h5A, 32'($urandom)};
        b.last = (idx == nb - 1);
        b.keep = b.last ? (8'hFF >> (pkt % 4)) : 8'hFF;
        b.user = b.last & pkt[0];
        return b;
    endfunction

    task automatic push_rx(input int lane, input int pkt, input int nb);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b = mk_beat(lane, pkt, i, nb);
            rx_src_q[lane].push_back(b);
            rx_exp.push_back(b);
        end
    endtask

    // dest is the lane the packet should land on; expect=0 for dropped packets.
    task automatic push_tx(input int dest, input int pkt, input int nb, input bit expect_out);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b = mk_beat(dest, pkt, i, nb);
            tx_src_q.push_back(b);
            if (expect_out) tx_exp.push_back(b);
        end
    endtask

    function automatic int pending();
        int n;
        n = rx_exp.size() + tx_exp.size() + tx_src_q.size();
        for (int l = 0; l < LANES; l++) n += rx_src_q[l].size();
        return n;
    endfunction

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        int left;
        n = 0;
        left = pending();
        while (left != 0 && n < max_cyc) begin
            @(negedge clock);
            #1;
            n++;
            left = pending();
        end
        repeat (4) @(negedge clock);
        check_eq(tag, 64'(left), 64'd0);
    endtask

    // Source drivers: handshakes sampled at negedge, queues advanced after posedge.
    initial begin
        bit    rx_hs [LANES];
        bit    tx_hs;
        beat_t b;
        forever begin
            @(negedge clock);
            for (int l = 0; l < LANES; l++) rx_hs[l] = s_rx_tvalid[l] & s_rx_tready[l];
            tx_hs = s_tx_tvalid & s_tx_tready;
            @(posedge clock);
            #1;
            for (int l = 0; l < LANES; l++) begin
                if (rx_hs[l] && rx_src_q[l].size() != 0) void'(rx_src_q[l].pop_front());
                if (rx_src_q[l].size() != 0) begin
                    b = rx_src_q[l][0];
                    s_rx_tvalid[l]             = 1'b1;
                    s_rx_tdata[l*DW +: DW]     = b.data;
                    s_rx_tkeep[l*KW +: KW]     = b.keep;
                    s_rx_tuser[l]              = b.user;
                    s_rx_tlast[l]              = b.last;
                end else begin
                    s_rx_tvalid[l] = 1'b0;
                end
            end
            if (tx_hs && tx_src_q.size() != 0) void'(tx_src_q.pop_front());
            if (tx_src_q.size() != 0) begin
                b = tx_src_q[0];
                s_tx_tvalid = 1'b1;
                s_tx_tdata  = b.data;
                s_tx_tkeep  = b.keep;
                s_tx_tuser  = b.user;
                s_tx_tlast  = b.last;
            end else begin
                s_tx_tvalid = 1'b0;
            end
            m_tx_tready = tx_rand_rdy ? 4'($urandom) : 4'hF;
        end
    end

    // Output monitor / scoreboard compare.
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            if (m_rx_tvalid && m_rx_tready) begin
                if (rx_exp.size() == 0) begin
                    check_eq("rx_unexpected", 64'd1, 64'd0);
                end else begin
                    e = rx_exp.pop_front();
                    check_eq("rx_data", m_rx_tdata, e.data);
                    check_eq("rx_keep", 64'(m_rx_tkeep), 64'(e.keep));
                    check_eq("rx_user", 64'(m_rx_tuser), 64'(e.user));
                    check_eq("rx_last", 64'(m_rx_tlast), 64'(e.last));
                end
                rx_seen++;
            end
            if (|m_tx_tvalid) check_eq("tx_onehot", 64'($countones(m_tx_tvalid)), 64'd1);
            for (int i = 0; i < LANES; i++) begin
                if (m_tx_tvalid[i] && tx_exp.size() == 0) begin
                    check_eq("tx_unexpected", 64'd1, 64'd0);
                end else if (m_tx_tvalid[i] && m_tx_tready[i]) begin
                    e = tx_exp.pop_front();
                    check_eq("tx_lane", 64'(i), 64'(e.lane));
                    check_eq("tx_data", m_tx_tdata[i*DW +: DW], e.data);
                    check_eq("tx_keep", 64'(m_tx_tkeep[i*KW +: KW]), 64'(e.keep));
                    check_eq("tx_user", 64'(m_tx_tuser[i]), 64'(e.user));
                    check_eq("tx_last", 64'(m_tx_tlast[i]), 64'(e.last));
                end
            end
            if (s_tx_tvalid && s_tx_tready) tx_seen++;
            if (s_tx_tvalid && !s_tx_tready) tx_stalls++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        reset       = 1'b1;
        tx_lane_sel = 3'd2;
        s_tx_tdata  = '0;
        s_tx_tkeep  = '0;
        s_tx_tuser  = 1'b0;
        s_tx_tlast  = 1'b0;
        s_tx_tvalid = 1'b0;
        m_tx_tready = '1;
        s_rx_tdata  = '0;
        s_rx_tkeep  = '0;
        s_rx_tuser  = '0;
        s_rx_tlast  = '0;
        s_rx_tvalid = '0;
        m_rx_tready = 1'b1;
        stat_lane   = 3'd0;
        // lane3..lane0: 0x1230 down, 0x00A5 up, 0x0000 down, 0x0001 up
        lane_status = {16'h1230, 16'h00A5, 16'h0000, 16'h0001};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_m_rx_tvalid", 64'(m_rx_tvalid), 64'd0);
        check_eq("rst_s_rx_tready", 64'(s_rx_tready), 64'd0);
        check_eq("rst_s_tx_tready", 64'(s_tx_tready), 64'd0);
        check_eq("rst_m_tx_tvalid", 64'(m_tx_tvalid), 64'd0);
        check_eq("rst_eth_status", 64'(eth_status), 64'd0);
        check_eq("rst_stat_rx", 64'(stat_rx_pkts), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // eth_status follows the selected lane one cycle later
        @(negedge clock);
        @(negedge clock);
        check_eq("status_sel2", 64'(eth_status), 64'h00A5);
        tx_lane_sel = 3'd5;
        @(negedge clock);
        @(negedge clock);
        check_eq("status_sel5", 64'(eth_status), 64'd0);
        tx_lane_sel = 3'd3;
        @(negedge clock);
        @(negedge clock);
        check_eq("status_sel3", 64'(eth_status), 64'h1230);

        // 1: four simultaneous 3-beat packets come out in lane order
        for (int l = 0; l < LANES; l++) push_rx(l, 10 + l, 3);
        wait_idle("t1_drain", 200);

        // 2: 5-beat packet to lane 2 under random backpressure
        tx_lane_sel = 3'd2;
        tx_rand_rdy = 1'b1;
        push_tx(2, 20, 5, 1'b1);
        wait_idle("t2_drain", 400);
        tx_rand_rdy = 1'b0;

        // 3: lane 1 link down -> packet sunk, no lane output
        tx_lane_sel = 3'd1;
        tx_stalls   = 0;
        base        = tx_seen;
        push_tx(1, 30, 4, 1'b0);
        wait_idle("t3_drain", 100);
        check_eq("t3_accepted", 64'(tx_seen - base), 64'd4);
        check_eq("t3_stalls", 64'(tx_stalls), 64'd1);
        stat_lane = 3'd1;
        #1;
        check_eq("t3_drops_lane1", 64'(stat_tx_drops), StatsOn ? 64'd1 : 64'd0);

        // 4: select change mid-packet ignored; next (single-beat) packet goes to lane 0
        tx_lane_sel = 3'd2;
        base        = tx_seen;
        push_tx(2, 40, 6, 1'b1);
        push_tx(0, 41, 1, 1'b1);
        n = 0;
        while (tx_seen < base + 3 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        tx_lane_sel = 3'd0;
        wait_idle("t4_drain", 100);

        // 5: reset during beat 2 of a lane-1 packet
        base = rx_seen;
        push_rx(1, 50, 5);
        n = 0;
        while (rx_seen < base + 1 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("t5_m_rx_tvalid", 64'(m_rx_tvalid), 64'd0);
        check_eq("t5_s_rx_tready", 64'(s_rx_tready), 64'd0);
        check_eq("t5_s_tx_tready", 64'(s_tx_tready), 64'd0);
        check_eq("t5_m_tx_tvalid", 64'(m_tx_tvalid), 64'd0);
        rx_src_q[1].delete();
        rx_exp.delete();
        s_rx_tvalid = '0;
        @(posedge clock);
        #1 reset = 1'b0;
        push_rx(0, 52, 2);
        push_rx(1, 53, 2);
        wait_idle("t5_drain", 100);
        stat_lane = 3'd0;
        #1;
        check_eq("t5_rx_pkts_lane0", 64'(stat_rx_pkts), StatsOn ? 64'd1 : 64'd0);

        // 6: counter saturation on lane 3
`ifdef ETH_LANE_MUX_STATS_EN
        @(negedge clock);
        force dut.gen_stats[3].rx_pkts_q = 32'hFFFF_FFFE;
        @(negedge clock);
        release dut.gen_stats[3].rx_pkts_q;
`endif
        for (int p = 0; p < 3; p++) push_rx(3, 60 + p, 1);
        wait_idle("t6_drain", 100);
        stat_lane = 3'd3;
        #1;
        check_eq("t6_rx_pkts_sat", 64'(stat_rx_pkts), StatsOn ? 64'hFFFF_FFFF : 64'd0);
        check_eq("t6_tx_drops_lane3", 64'(stat_tx_drops), 64'd0);
        stat_lane = 3'd5;
        #1;
        check_eq("t6_rx_pkts_sel5", 64'(stat_rx_pkts), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
